// File: rtl/main_memory.sv
// Fixed-latency backing store for MemorySystem: block refill bursts and byte write-through.
// Define MAIN_MEM_INIT_EN to have reset also load mem[i] = i; otherwise contents survive reset.
module main_memory #(
  parameter int ADDR_W      = 6,
  parameter int DATA_W      = 8,
  parameter int BLOCK_WORDS = 4,
  parameter int LATENCY     = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              done
);

  localparam int BEAT_W = $clog2(BLOCK_WORDS);
  localparam int LAT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int DEPTH  = 1 << ADDR_W;

  localparam logic [LAT_W-1:0]  LAT_LAST  = LAT_W'(LATENCY - 1);
  localparam logic [LAT_W-1:0]  LAT_PRE   = LAT_W'((LATENCY > 1) ? LATENCY - 2 : 0);
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BLOCK_WORDS - 1);
  localparam logic [BEAT_W-1:0] BEAT_PRE  = BEAT_W'(BLOCK_WORDS - 2);

  typedef enum logic [1:0] {IDLE, RD_WAIT, RD_BURST, WR_WAIT} state_t;

  state_t              state, state_d;
  logic [LAT_W-1:0]    lat_cnt, lat_d;
  logic [BEAT_W-1:0]   beat_cnt, beat_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                rvalid_d, done_d, load_rdata, mem_we;
  logic [ADDR_W-1:0]   rd_idx;
  logic [DATA_W-1:0]   mem [DEPTH];

  assign req_ready = (state == IDLE);

  always_comb begin
    state_d    = state;
    lat_d      = lat_cnt;
    beat_d     = beat_cnt;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rvalid_d   = 1'b0;
    done_d     = 1'b0;
    load_rdata = 1'b0;
    mem_we     = 1'b0;
    rd_idx     = {addr_q[ADDR_W-1:BEAT_W], beat_cnt};
    // rvalid/done/rdata are registered, so each state decides what the next cycle shows
    case (state)
      IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          wdata_d = req_wdata;
          lat_d   = '0;
          beat_d  = '0;
          if (req_write) begin
            state_d = WR_WAIT;
            done_d  = (LATENCY == 1);
          end else if (LATENCY == 1) begin
            state_d    = RD_BURST;
            rvalid_d   = 1'b1;
            load_rdata = 1'b1;
            rd_idx     = {req_addr[ADDR_W-1:BEAT_W], {BEAT_W{1'b0}}};
          end else begin
            state_d = RD_WAIT;
          end
        end
      end
      RD_WAIT: begin
        if (lat_cnt == LAT_PRE) begin
          state_d    = RD_BURST;
          lat_d      = '0;
          beat_d     = '0;
          rvalid_d   = 1'b1;
          load_rdata = 1'b1;
          rd_idx     = {addr_q[ADDR_W-1:BEAT_W], {BEAT_W{1'b0}}};
        end else begin
          lat_d = lat_cnt + 1'b1;
        end
      end
      RD_BURST: begin
        if (beat_cnt == BEAT_LAST) begin
          state_d = IDLE;
          beat_d  = '0;
        end else begin
          beat_d     = beat_cnt + 1'b1;
          rvalid_d   = 1'b1;
          load_rdata = 1'b1;
          rd_idx     = {addr_q[ADDR_W-1:BEAT_W], beat_cnt + 1'b1};
          done_d     = (beat_cnt == BEAT_PRE);
        end
      end
      WR_WAIT: begin
        if (lat_cnt == LAT_LAST) begin
          mem_we  = 1'b1;
          state_d = IDLE;
          lat_d   = '0;
        end else begin
          lat_d  = lat_cnt + 1'b1;
          done_d = (lat_cnt == LAT_PRE);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      lat_cnt  <= '0;
      beat_cnt <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rvalid   <= 1'b0;
      rdata    <= '0;
      done     <= 1'b0;
    end else begin
      state    <= state_d;
      lat_cnt  <= lat_d;
      beat_cnt <= beat_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rvalid   <= rvalid_d;
      done     <= done_d;
      if (load_rdata) rdata <= mem[rd_idx];
    end
  end

  // A write landing on a reset cycle is dropped along with the rest of the request
`ifdef MAIN_MEM_INIT_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= DATA_W'(i);
    end else if (mem_we) begin
      mem[addr_q] <= wdata_q;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (reset && mem_we) mem[addr_q] <= wdata_q;
  end
`endif

endmodule

// File: tb/tb_main_memory.sv
// Directed bench for main_memory: a LATENCY=3 instance and a LATENCY=1 instance.
// Without MAIN_MEM_INIT_EN the bench first writes mem[i] = i so expectations match either build.
module tb_main_memory;

  logic       clk = 1'b0;
  logic       reset;
  logic       sel;
  logic       req_valid;
  logic       req_write;
  logic [5:0] req_addr;
  logic [7:0] req_wdata;

  logic       ready3, rvalid3, done3, ready1, rvalid1, done1;
  logic [7:0] rdata3, rdata1;

  wire        valid3     = req_valid & ~sel;
  wire        valid1     = req_valid & sel;
  wire        obs_ready  = sel ? ready1 : ready3;
  wire        obs_rvalid = sel ? rvalid1 : rvalid3;
  wire        obs_done   = sel ? done1 : done3;
  wire [7:0]  obs_rdata  = sel ? rdata1 : rdata3;

  int         tests_run = 0;
  int         tests_failed = 0;
  logic [7:0] model [2][64];

  always #5 clk = ~clk;

  main_memory #(.ADDR_W(6), .DATA_W(8), .BLOCK_WORDS(4), .LATENCY(3)) dut3 (
    .clk(clk), .reset(reset), .req_valid(valid3), .req_ready(ready3),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .rvalid(rvalid3), .rdata(rdata3), .done(done3)
  );

  main_memory #(.ADDR_W(6), .DATA_W(8), .BLOCK_WORDS(4), .LATENCY(1)) dut1 (
    .clk(clk), .reset(reset), .req_valid(valid1), .req_ready(ready1),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .rvalid(rvalid1), .rdata(rdata1), .done(done1)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic resetModel;
`ifdef MAIN_MEM_INIT_EN
    for (int i = 0; i < 64; i++) begin
      model[0][i] = 8'(i);
      model[1][i] = 8'(i);
    end
`endif
  endtask

  // Handshake in the current cycle, then walk every cycle up to the ready return.
  task automatic writeByte(input logic [5:0] addr, input logic [7:0] data, input int lat);
    checkOutput("wr_ready_idle", obs_ready, 1);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = addr;
    req_wdata = data;
    tick();
    req_valid = 1'b0;
    req_wdata = ~data;
    for (int c = 1; c <= lat + 1; c++) begin
      checkOutput("wr_done", obs_done, (c == lat));
      checkOutput("wr_rvalid", obs_rvalid, 0);
      checkOutput("wr_ready", obs_ready, (c == lat + 1));
      if (c <= lat) tick();
    end
    model[sel][addr] = data;
  endtask

  task automatic readBlock(input logic [5:0] addr, input int lat, input bit chg, input logic [5:0] addr2);
    logic [7:0] last;
    logic       inb;
    last = 8'h00;
    checkOutput("rd_ready_idle", obs_ready, 1);
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = addr;
    tick();
    req_valid = 1'b0;
    if (chg) req_addr = addr2;
    for (int c = 1; c <= lat + 4; c++) begin
      inb = (c >= lat) && (c <= lat + 3);
      checkOutput("rd_rvalid", obs_rvalid, inb);
      checkOutput("rd_done", obs_done, (c == lat + 3));
      checkOutput("rd_ready", obs_ready, (c == lat + 4));
      if (inb) begin
        last = model[sel][{addr[5:2], 2'(c - lat)}];
        checkOutput("rd_data", obs_rdata, last);
      end
      if (c == lat + 4) checkOutput("rd_hold", obs_rdata, last);
      else tick();
    end
  endtask

  task automatic applyStimulus;
    int beats;
    int dones;
    logic [7:0] exp_data;

    sel       = 1'b0;
    reset     = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    for (int i = 0; i < 64; i++) begin
      model[0][i] = 8'(i);
      model[1][i] = 8'(i);
    end
    tick();
    tick();
    checkOutput("rst_ready", ready3, 1);
    checkOutput("rst_rvalid", rvalid3, 0);
    checkOutput("rst_rdata", rdata3, 0);
    checkOutput("rst_done", done3, 0);
    checkOutput("rst_ready_l1", ready1, 1);
    reset = 1'b1;
    tick();

`ifndef MAIN_MEM_INIT_EN
    for (int i = 0; i < 64; i++) writeByte(6'(i), 8'(i), 3);
`endif

    readBlock(6'h09, 3, 1'b0, 6'h00);

    writeByte(6'h3E, 8'hA5, 3);
    readBlock(6'h3C, 3, 1'b0, 6'h00);

    // Back-to-back reads of blocks 0 and 1 with req_valid held high
    beats = 0;
    dones = 0;
    checkOutput("b2b_ready_idle", obs_ready, 1);
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 6'h00;
    tick();
    req_addr = 6'h04;
    for (int c = 1; c <= 14; c++) begin
      if (c == 8) req_valid = 1'b0;
      checkOutput("b2b_rvalid", obs_rvalid, ((c >= 3 && c <= 6) || (c >= 10 && c <= 13)));
      checkOutput("b2b_done", obs_done, (c == 6 || c == 13));
      checkOutput("b2b_ready", obs_ready, (c == 7 || c == 14));
      if (obs_rvalid) begin
        beats++;
        exp_data = (c <= 6) ? model[0][c - 3] : model[0][4 + c - 10];
        checkOutput("b2b_data", obs_rdata, exp_data);
      end
      if (obs_done) dones++;
      if (c < 14) tick();
    end
    checkOutput("b2b_beats", beats, 8);
    checkOutput("b2b_dones", dones, 2);

    readBlock(6'h14, 3, 1'b1, 6'h20);

    // Reset lands one cycle before the write's commit cycle
    checkOutput("abort_ready_idle", obs_ready, 1);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 6'h05;
    req_wdata = 8'h77;
    tick();
    req_valid = 1'b0;
    checkOutput("abort_done_c1", obs_done, 0);
    tick();
    checkOutput("abort_done_c2", obs_done, 0);
    reset = 1'b0;
    tick();
    checkOutput("abort_done_c3", obs_done, 0);
    checkOutput("abort_ready_c3", obs_ready, 1);
    checkOutput("abort_rvalid_c3", obs_rvalid, 0);
    checkOutput("abort_rdata_c3", obs_rdata, 0);
    reset = 1'b1;
    resetModel();
    tick();
    checkOutput("abort_done_c4", obs_done, 0);
    checkOutput("abort_ready_c4", obs_ready, 1);
    readBlock(6'h04, 3, 1'b0, 6'h00);

    sel = 1'b1;
    writeByte(6'h10, 8'hC0, 1);
    writeByte(6'h11, 8'hC1, 1);
    writeByte(6'h12, 8'hC2, 1);
    writeByte(6'h13, 8'hC3, 1);
    readBlock(6'h12, 1, 1'b0, 6'h00);
  endtask

  initial begin
    applyStimulus();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/main_memory.md
# main_memory

Backing store behind the cache `MemorySystem`. Serves block refills on a cache miss and single-byte write-through stores, with a fixed programmable access latency. It holds the full 64-byte, 8-bit-wide address space. It accepts one request at a time through a valid/ready handshake and returns refill data as a burst of consecutive beats.

## Interface

Parameters:
- `ADDR_W`, 6, byte address width (memory depth = 2^ADDR_W bytes)
- `DATA_W`, 8, data width per byte/beat
- `BLOCK_WORDS`, 4, bytes per cache block / beats per refill (power of two, ≥2)
- `LATENCY`, 3, cycles from request acceptance to first response (≥1)

Ports:
- `clk`  in  1  system clock; all logic is on the rising edge
- `reset`  in  1  synchronous, active-low reset; one clock, reset is synchronous and active-low
- `req_valid`  in  1  request present
- `req_ready`  out  1  block can accept a request (high only in IDLE)
- `req_write`  in  1  1 = byte write, 0 = block read
- `req_addr`  in  ADDR_W  byte address; low log2(BLOCK_WORDS) bits are ignored for reads
- `req_wdata`  in  DATA_W  write byte
- `rvalid`  out  1  refill beat valid
- `rdata`  out  DATA_W  refill beat data
- `done`  out  1  one-cycle pulse when the request completes

## Operation

- A handshake occurs in any cycle where `req_valid && req_ready` at the rising edge.
- `req_write`, `req_addr` and `req_wdata` are captured at the handshake; later input changes are ignored.
- FSM states are IDLE, RD_WAIT, RD_BURST and WR_WAIT. `req_ready` is 1 exactly when the state is IDLE.
- IDLE:
  - A read handshake goes to RD_WAIT with the latency counter loaded.
  - A write handshake goes to WR_WAIT.
  - With no handshake, the FSM stays in IDLE.
- RD_WAIT: counts LATENCY−1 cycles, then goes to RD_BURST with the beat counter at 0.
- RD_BURST:
  - Each cycle asserts `rvalid` with `rdata = mem[{block, beat}]`, for beats 0..BLOCK_WORDS−1 in ascending order.
  - `done` is asserted together with the last beat.
  - The FSM then returns to IDLE.
- WR_WAIT:
  - Counts LATENCY cycles.
  - On the final cycle, `mem[addr] <= wdata` and `done` pulses; the FSM then returns to IDLE.
  - No `rvalid` is produced for a write.
- The beat counter covers only the aligned block and never wraps into the next block; block 15 (addresses 60–63) is legal.
- Reset values: state IDLE, `req_ready` 1, `rvalid` 0, `rdata` 0, `done` 0, both counters 0.
- Reset mid-operation:
  - Any in-flight request is aborted.
  - A pending write whose commit cycle has not been reached is not committed.
  - No further beats or `done` are produced.
- `rdata` holds its last value when `rvalid` is 0.

## Timing

- A handshake in cycle T starts the latency window.
- Read:
  - `rvalid` is high in cycles T+LATENCY through T+LATENCY+BLOCK_WORDS−1.
  - `done` is high in cycle T+LATENCY+BLOCK_WORDS−1.
  - `req_ready` returns in cycle T+LATENCY+BLOCK_WORDS.
- Write:
  - `done` is high in cycle T+LATENCY.
  - The memory updates at the end of that cycle.
  - `req_ready` returns in cycle T+LATENCY+1.
- A new request may be accepted in the first cycle `req_ready` is high; there are no dead cycles beyond that.
- A read immediately after a write to the same block returns the newly written byte.
- All outputs are registered; none depend combinationally on the request inputs.

## Configuration

- `MAIN_MEM_INIT_EN`:
  - Defined: reset also initialises the array to `mem[i] = i` (truncated to DATA_W) over all 2^ADDR_W locations. This runs in the same single reset cycle.
  - Undefined: reset touches only control state. Array contents are preserved across reset and are undefined (X) until written.

## Test plan

- `MAIN_MEM_INIT_EN` defined, reset released, read at addr 0x09 (LATENCY=3):
  - handshake at T
  - `rvalid` at T+3..T+6 with data 0x08, 0x09, 0x0A, 0x0B
  - `done` at T+6, `req_ready` at T+7
- Write 0xA5 to addr 0x3E, then read at addr 0x3C:
  - write `done` at T+3
  - read beats 0x3C, 0x3D, 0xA5, 0x3F
- Back-to-back: hold `req_valid` high with two reads (blocks 0 and 1):
  - second handshake occurs exactly in the cycle `req_ready` rises
  - 8 beats total, two `done` pulses
  - `req_ready` is 0 throughout both bursts
- Inputs changed after handshake: `req_addr` switched to 0x20 while in RD_WAIT
  - beats still come from the originally captured block
- Reset asserted during WR_WAIT of a write 0x77 to 0x05 (LATENCY=3), one cycle before the commit cycle:
  - no `done`; `req_ready` is 1 after reset
  - a subsequent read of block 1 returns 0x05 at offset 1 (macro defined)
- LATENCY=1 build: a read handshake at T gives `rvalid` at T+1..T+4, and a write `done` at T+1.
